// File: rtl/rom_c.sv
// FM-index C table: four loadable per-symbol occurrence counts, with a registered
// prefix-sum lookup, a registered saturated total and a saturation flag.
module rom_c #(
    parameter int DATA_W    = 8,
    parameter int INIT_CNT0 = 2,
    parameter int INIT_CNT1 = 3,
    parameter int INIT_CNT2 = 2,
    parameter int INIT_CNT3 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [1:0]        symbol,
    output logic [DATA_W-1:0] data,
    input  logic              ld_en,
    input  logic [1:0]        ld_sym,
    input  logic [DATA_W-1:0] ld_cnt,
    output logic [DATA_W-1:0] total,
    output logic              ovf
);

    // Two guard bits: the sum of four DATA_W-bit counts cannot wrap.
    localparam int SW = DATA_W + 2;
    localparam logic [DATA_W-1:0] MAXV = '1;

    // Reset-time prefix sums, computed from the parameters at elaboration.
    localparam logic [SW-1:0] INIT_R2 = SW'(INIT_CNT0) + SW'(INIT_CNT1);
    localparam logic [SW-1:0] INIT_R3 = INIT_R2 + SW'(INIT_CNT2);
    localparam logic [SW-1:0] INIT_RT = INIT_R3 + SW'(INIT_CNT3);
    localparam logic INIT_OVF = (INIT_R2 > SW'(MAXV)) || (INIT_R3 > SW'(MAXV)) ||
                                (INIT_RT > SW'(MAXV));

    // Clamp a wide sum to the largest DATA_W-bit value.
    function automatic logic [DATA_W-1:0] sat(input logic [SW-1:0] v);
        return (v > SW'(MAXV)) ? MAXV : v[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] r_cnt [4];
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_total;
    logic              r_ovf;

    logic [SW-1:0]     w_raw2;
    logic [SW-1:0]     w_raw3;
    logic [SW-1:0]     w_raw_tot;
    logic [DATA_W-1:0] w_c [4];
    logic              w_ovf;

    // Prefix sums and saturation flag, combinational from the current counts.
    always_comb begin
        w_raw2    = SW'(r_cnt[0]) + SW'(r_cnt[1]);
        w_raw3    = w_raw2 + SW'(r_cnt[2]);
        w_raw_tot = w_raw3 + SW'(r_cnt[3]);
        w_c[0]    = '0;
        w_c[1]    = r_cnt[0];
        w_c[2]    = sat(w_raw2);
        w_c[3]    = sat(w_raw3);
        w_ovf     = (w_raw2 > SW'(MAXV)) || (w_raw3 > SW'(MAXV)) ||
                    (w_raw_tot > SW'(MAXV));
    end

    // Count storage; a load becomes visible to the table on the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt[0] <= DATA_W'(INIT_CNT0);
            r_cnt[1] <= DATA_W'(INIT_CNT1);
            r_cnt[2] <= DATA_W'(INIT_CNT2);
            r_cnt[3] <= DATA_W'(INIT_CNT3);
        end else if (ld_en) begin
            r_cnt[ld_sym] <= ld_cnt;
        end
    end

    // Registered outputs, all taken from the pre-load counts; read data is gated by ce.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_total <= sat(INIT_RT);
            r_ovf   <= INIT_OVF;
        end else begin
            r_data  <= ce ? w_c[symbol] : '0;
            r_total <= sat(w_raw_tot);
            r_ovf   <= w_ovf;
        end
    end

    assign data  = r_data;
    assign total = r_total;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_rom_c.sv
// Bench for rom_c: directed steps from the block's usage scenarios, then a randomized
// run checked against an array-based model of the count table.
module tb_rom_c;

    localparam int DW   = 8;
    localparam int MAXV = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic [1:0]    symbol;
    logic [DW-1:0] data;
    logic          ld_en;
    logic [1:0]    ld_sym;
    logic [DW-1:0] ld_cnt;
    logic [DW-1:0] total;
    logic          ovf;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: plain integer occurrence counts.
    int cnt_m [4];
    int exp_data;
    int exp_total;
    int exp_ovf;

    rom_c #(.DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .symbol(symbol), .data(data),
        .ld_en(ld_en), .ld_sym(ld_sym), .ld_cnt(ld_cnt), .total(total), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic int satv(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    // Unsaturated number of characters smaller than s.
    function automatic int csum(input int s);
        int acc = 0;
        for (int i = 0; i < s; i++) acc += cnt_m[i];
        return acc;
    endfunction

    function automatic int any_sat();
        for (int s = 1; s <= 4; s++) if (csum(s) > MAXV) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        cnt_m[0] = 2; cnt_m[1] = 3; cnt_m[2] = 2; cnt_m[3] = 1;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, then check all outputs.
    task automatic step(input bit rn, input bit c, input logic [1:0] s,
                        input bit le, input logic [1:0] ls, input int lc);
        rst_n = rn; ce = c; symbol = s; ld_en = le; ld_sym = ls; ld_cnt = DW'(lc);
        @(posedge clk);
        if (!rn) begin
            model_reset();
            exp_data  = 0;
            exp_total = satv(csum(4));
            exp_ovf   = any_sat();
        end else begin
            exp_data  = c ? satv(csum(int'(s))) : 0;
            exp_total = satv(csum(4));
            exp_ovf   = any_sat();
            if (le) cnt_m[ls] = lc;
        end
        #1;
        chk("data",  int'(data),  exp_data);
        chk("total", int'(total), exp_total);
        chk("ovf",   int'(ovf),   exp_ovf);
    endtask

    initial begin
        logic [2:0] wide;
        rst_n = 1'b0; ce = 1'b0; symbol = '0; ld_en = 1'b0; ld_sym = '0; ld_cnt = '0;
        model_reset();

        // Reset, then two idle cycles
        step(0, 0, 0, 0, 0, 0);
        chk("rst_data", int'(data), 0);
        chk("rst_total", int'(total), 8);
        chk("rst_ovf", int'(ovf), 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("idle_data", int'(data), 0);
        chk("idle_total", int'(total), 8);

        // Read every table entry
        step(1, 1, 0, 0, 0, 0); chk("c0", int'(data), 0);
        step(1, 1, 1, 0, 0, 0); chk("c1", int'(data), 2);
        step(1, 1, 2, 0, 0, 0); chk("c2", int'(data), 5);
        step(1, 1, 3, 0, 0, 0); chk("c3", int'(data), 7);

        // Wide symbol truncates; ce low gates the output
        wide = 3'd4;
        step(1, 1, wide[1:0], 0, 0, 0); chk("trunc", int'(data), 0);
        step(1, 0, 3, 0, 0, 0); chk("gated", int'(data), 0);

        // Load concurrent with read returns pre-load value
        step(1, 1, 2, 1, 1, 10); chk("ld_pre", int'(data), 5);
        step(1, 1, 2, 0, 0, 0);
        chk("ld_post", int'(data), 12);
        chk("ld_total", int'(total), 15);

        // Saturation
        step(1, 0, 0, 1, 0, 200);
        step(1, 0, 0, 1, 1, 100);
        step(1, 1, 2, 0, 0, 0);
        chk("sat_c2", int'(data), 255);
        chk("sat_total", int'(total), 255);
        chk("sat_ovf", int'(ovf), 1);

        // Reset mid-operation restores initial counts
        step(0, 1, 2, 1, 2, 99);
        chk("rst2_data", int'(data), 0);
        chk("rst2_total", int'(total), 8);
        chk("rst2_ovf", int'(ovf), 0);
        step(1, 1, 2, 0, 0, 0); chk("rst2_c2", int'(data), 5);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            bit rn, c, le;
            logic [1:0] s, ls;
            int lc;
            rn = ($urandom_range(0, 49) != 0);
            c  = ($urandom_range(0, 3) != 0);
            le = ($urandom_range(0, 2) == 0);
            s  = 2'($urandom_range(0, 3));
            ls = 2'($urandom_range(0, 3));
            lc = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 40))
                                             : int'($urandom_range(0, MAXV));
            step(rn, c, s, le, ls, lc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
